// File: rtl/dmi_arbiter_pkg.sv
// Shared definitions for the DMI arbiter slice.
//   - DMI request/response field widths and packed struct types
//   - DMI response codes
//   - arbiter state encoding
package dmi_arbiter_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;
  localparam int DMI_OP_W   = 2;
  localparam int DMI_RSP_W  = 2;

  localparam int DMI_REQ_W  = DMI_ADDR_W + DMI_DATA_W + DMI_OP_W;  // 41
  localparam int DMI_RESP_W = DMI_DATA_W + DMI_RSP_W;              // 34

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] data;
    logic [DMI_OP_W-1:0]   op;
  } dmi_req_t;

  typedef struct packed {
    logic [DMI_DATA_W-1:0] data;
    logic [DMI_RSP_W-1:0]  resp;
  } dmi_resp_t;

  localparam logic [DMI_RSP_W-1:0] DMI_RESP_SUCCESS = 2'd0;
  localparam logic [DMI_RSP_W-1:0] DMI_RESP_FAILED  = 2'd2;
  localparam logic [DMI_RSP_W-1:0] DMI_RESP_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

endpackage : dmi_arbiter_pkg

// File: rtl/dmi_arbiter_rr_arb2.sv
// Two-input round-robin picker (purely combinational).
//   valid     in  2  request valid per input
//   prio      in  1  input that wins when both are valid
//   grant     out 1  index of the winning input
//   valid_any out 1  at least one input is valid
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       grant,
  output logic       valid_any
);

  // With a single requester it wins outright; prio only breaks ties.
  assign grant     = (valid[0] && valid[1]) ? prio : valid[1];
  assign valid_any = |valid;

endmodule : rr_arb2

// File: rtl/dmi_arbiter.sv
// Shares one Debug Module DMI port between two DTM requesters.
// One transaction in flight; round-robin grant; responses routed back to the
// issuing requester; a response timeout returns an error and the late DM
// response is swallowed in DRAIN.
//   CLK_I / RST_NI                       clock, async active-low reset
//   REQx_VALID_I / REQx_READY_O / REQx_I request from requester x
//   RESPx_VALID_O / RESPx_READY_I / RESPx_O response to requester x
//   DMI_REQ_*                            request channel to the DM
//   DMI_RESP_*                           response channel from the DM
//   BUSY_O                               transaction in flight
//   TIMEOUT_O                            one-cycle pulse when a timeout fires
module dmi_arbiter
  import dmi_arbiter_pkg::*;
#(
  parameter int          REQ_WIDTH      = DMI_REQ_W,
  parameter int          RESP_WIDTH     = DMI_RESP_W,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [1:0]  ERR_RESP       = DMI_RESP_FAILED
) (
  input  logic                  CLK_I,
  input  logic                  RST_NI,
  input  logic                  REQ0_VALID_I,
  output logic                  REQ0_READY_O,
  input  logic [REQ_WIDTH-1:0]  REQ0_I,
  output logic                  RESP0_VALID_O,
  input  logic                  RESP0_READY_I,
  output logic [RESP_WIDTH-1:0] RESP0_O,
  input  logic                  REQ1_VALID_I,
  output logic                  REQ1_READY_O,
  input  logic [REQ_WIDTH-1:0]  REQ1_I,
  output logic                  RESP1_VALID_O,
  input  logic                  RESP1_READY_I,
  output logic [RESP_WIDTH-1:0] RESP1_O,
  output logic                  DMI_REQ_VALID_O,
  input  logic                  DMI_REQ_READY_I,
  output logic [REQ_WIDTH-1:0]  DMI_REQ_O,
  input  logic                  DMI_RESP_VALID_I,
  output logic                  DMI_RESP_READY_O,
  input  logic [RESP_WIDTH-1:0] DMI_RESP_I,
  output logic                  BUSY_O,
  output logic                  TIMEOUT_O
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_SAT  = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [RESP_WIDTH-1:0] ERR_WORD = RESP_WIDTH'(ERR_RESP);

  arb_state_e             state_reg, state_next;
  logic                   prio_reg, prio_next;
  logic                   grant_reg, grant_next;
  logic [REQ_WIDTH-1:0]   req_q_reg, req_q_next;
  logic [CNT_W-1:0]       counter_reg, counter_next;

  logic                   arb_grant;
  logic                   arb_any;
  logic                   accept;
  logic                   resp_sel;
  logic                   err_pending;
  logic                   gnt_resp_ready;
  logic [RESP_WIDTH-1:0]  resp_word;
  logic [1:0]             req_ready_vec;
  logic [1:0]             resp_valid_vec;
  logic [RESP_WIDTH-1:0]  resp_data_vec [2];

  rr_arb2 u_arb (
    .valid     ({REQ1_VALID_I, REQ0_VALID_I}),
    .prio      (prio_reg),
    .grant     (arb_grant),
    .valid_any (arb_any)
  );

  // Gating with RST_NI keeps READY low while reset is held, so nothing is
  // acknowledged that the state register is about to forget.
  assign accept         = RST_NI && (state_reg == ST_IDLE) && arb_any;
  assign resp_sel       = (state_reg == ST_RESP);
  assign gnt_resp_ready = grant_reg ? RESP1_READY_I : RESP0_READY_I;

  // A real DM response always wins over the synthesized error, including in
  // the very cycle the counter reaches its limit.
  assign err_pending = TIMEOUT_EN && resp_sel && (counter_reg >= CNT_LAST) && !DMI_RESP_VALID_I;
  assign resp_word   = err_pending ? ERR_WORD : DMI_RESP_I;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready_vec[gi]  = accept && (arb_grant == 1'(gi));
      assign resp_valid_vec[gi] = resp_sel && (grant_reg == 1'(gi)) &&
                                  (DMI_RESP_VALID_I || err_pending);
      assign resp_data_vec[gi]  = (resp_sel && (grant_reg == 1'(gi))) ? resp_word : '0;
    end
  endgenerate

  assign REQ0_READY_O  = req_ready_vec[0];
  assign REQ1_READY_O  = req_ready_vec[1];
  assign RESP0_VALID_O = resp_valid_vec[0];
  assign RESP1_VALID_O = resp_valid_vec[1];
  assign RESP0_O       = resp_data_vec[0];
  assign RESP1_O       = resp_data_vec[1];

  assign DMI_REQ_VALID_O  = (state_reg == ST_REQ);
  assign DMI_REQ_O        = (state_reg == ST_REQ) ? req_q_reg : '0;
  assign DMI_RESP_READY_O = (resp_sel && gnt_resp_ready) || (state_reg == ST_DRAIN);
  assign BUSY_O           = (state_reg != ST_IDLE);
  // The counter moves past CNT_LAST in the first error cycle, so this
  // equality only holds once per timeout.
  assign TIMEOUT_O        = err_pending && (counter_reg == CNT_LAST);

  always_comb begin
    state_next   = state_reg;
    prio_next    = prio_reg;
    grant_next   = grant_reg;
    req_q_next   = req_q_reg;
    counter_next = counter_reg;
    case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          req_q_next = arb_grant ? REQ1_I : REQ0_I;
          grant_next = arb_grant;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (DMI_REQ_READY_I) begin
          counter_next = '0;
          state_next   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (TIMEOUT_EN && !DMI_RESP_VALID_I && (counter_reg != CNT_SAT)) begin
          counter_next = counter_reg + CNT_ONE;
        end
        if (DMI_RESP_VALID_I && gnt_resp_ready) begin
          prio_next  = ~grant_reg;
          state_next = ST_IDLE;
        end else if (err_pending && gnt_resp_ready) begin
          prio_next  = ~grant_reg;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (DMI_RESP_VALID_I) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_reg   <= ST_IDLE;
      prio_reg    <= 1'b0;
      grant_reg   <= 1'b0;
      req_q_reg   <= '0;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      prio_reg    <= prio_next;
      grant_reg   <= grant_next;
      req_q_reg   <= req_q_next;
      counter_reg <= counter_next;
    end
  end

endmodule : dmi_arbiter
